iic_access_arbiter: RTL and testbench



---
 rtl/iic_access_arbiter.sv | 213 +++++++++++++++++++++
 tb/tb_iic_access_arbiter.sv | 289 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/iic_access_arbiter.sv
// rtl/iic_access_arbiter.sv - round-robin arbiter sharing one IIC master; optional busy timeout via IIC_ARB_TIMEOUT_EN
module iic_access_arbiter #(
    parameter int NREQ     = 2,
    parameter int WR_PULSE = 10,
    parameter int TIMEOUT  = 1023
) (
    input  logic               clk_10MHz,
    input  logic               rst,
    input  logic [NREQ-1:0]    req,
    input  logic [8*NREQ-1:0]  req_dev,
    input  logic [16*NREQ-1:0] req_reg,
    input  logic [8*NREQ-1:0]  req_dat,
    input  logic [NREQ-1:0]    req_reg2,
    output logic [NREQ-1:0]    gnt,
    output logic [NREQ-1:0]    done,
    output logic [NREQ-1:0]    err,
    output logic [7:0]         Addr,
    output logic [15:0]        Reg_Addr,
    output logic [7:0]         Reg_Data,
    output logic               Reg2Addr,
    output logic               IIC_Write,
    input  logic               IIC_Busy,
    output logic               Ctrl_IIC
);

    localparam int PW = $clog2(NREQ);
    localparam int SW = PW + 1;
    localparam int CW = $clog2(WR_PULSE + 1);

    typedef enum logic [2:0] {
        IDLE,
        ISSUE,
        WAIT_BUSY,
        WAIT_DONE,
        FINISH
    } state_t;

    state_t          state;
    state_t          state_next;
    logic [PW-1:0]   ptr;
    logic [PW-1:0]   winner;
    logic [PW-1:0]   pick;
    logic            any_req;
    logic [CW-1:0]   wr_cnt;
    logic            busy_seen;

    logic [7:0]      dev_slot [NREQ];
    logic [15:0]     reg_slot [NREQ];
    logic [7:0]      dat_slot [NREQ];

`ifdef IIC_ARB_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT + 1);
    logic [TW-1:0]   to_cnt;
    logic            timed_out;
`endif

    // Unpack the flat requester buses into per-slot fields
    for (genvar g = 0; g < NREQ; g++) begin : g_slot
        assign dev_slot[g] = req_dev[8*g +: 8];
        assign reg_slot[g] = req_reg[16*g +: 16];
        assign dat_slot[g] = req_dat[8*g +: 8];
    end

    // Round-robin pick: first requesting slot at or after ptr, wrapping
    always_comb begin
        logic [SW-1:0] sum;
        logic [PW-1:0] idx;
        pick    = '0;
        any_req = 1'b0;
        sum     = '0;
        idx     = '0;
        for (int k = NREQ - 1; k >= 0; k--) begin
            sum = {1'b0, ptr} + SW'(k);
            if (sum >= SW'(NREQ)) begin
                sum = sum - SW'(NREQ);
            end
            idx = sum[PW-1:0];
            if (req[idx]) begin
                pick    = idx;
                any_req = 1'b1;
            end
        end
    end

    // FSM state register
    always_ff @(posedge clk_10MHz) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // FSM next-state and completion pulses to the winner
    always_comb begin
        state_next = state;
        done       = '0;
        err        = '0;
        case (state)
            IDLE: begin
                if (any_req && !IIC_Busy) begin
                    state_next = ISSUE;
                end
            end
            ISSUE: begin
                if (wr_cnt == CW'(WR_PULSE)) begin
                    state_next = WAIT_BUSY;
                end
            end
            WAIT_BUSY: begin
                if (IIC_Busy || busy_seen) begin
                    state_next = WAIT_DONE;
                end
`ifdef IIC_ARB_TIMEOUT_EN
                else if (to_cnt == TW'(TIMEOUT - 1)) begin
                    state_next = FINISH;
                end
`endif
            end
            WAIT_DONE: begin
                if (!IIC_Busy) begin
                    state_next = FINISH;
                end
            end
            FINISH: begin
                state_next = IDLE;
`ifdef IIC_ARB_TIMEOUT_EN
                if (timed_out) begin
                    err[winner] = 1'b1;
                end else begin
                    done[winner] = 1'b1;
                end
`else
                done[winner] = 1'b1;
`endif
            end
            default: state_next = IDLE;
        endcase
    end

    // Grant latching, strobe timing, busy capture and pointer advance
    always_ff @(posedge clk_10MHz) begin
        if (rst) begin
            ptr       <= '0;
            winner    <= '0;
            gnt       <= '0;
            Ctrl_IIC  <= 1'b0;
            IIC_Write <= 1'b0;
            wr_cnt    <= '0;
            busy_seen <= 1'b0;
            Addr      <= 8'h6C;
            Reg_Addr  <= 16'h0000;
            Reg_Data  <= 8'h00;
            Reg2Addr  <= 1'b1;
`ifdef IIC_ARB_TIMEOUT_EN
            to_cnt    <= '0;
            timed_out <= 1'b0;
`endif
        end else begin
            IIC_Write <= 1'b0;
            case (state)
                IDLE: begin
                    if (state_next == ISSUE) begin
                        winner    <= pick;
                        gnt       <= NREQ'(1) << pick;
                        Ctrl_IIC  <= 1'b1;
                        Addr      <= dev_slot[pick];
                        Reg_Addr  <= reg_slot[pick];
                        Reg_Data  <= dat_slot[pick];
                        Reg2Addr  <= req_reg2[pick];
                        wr_cnt    <= '0;
                        busy_seen <= 1'b0;
`ifdef IIC_ARB_TIMEOUT_EN
                        to_cnt    <= '0;
                        timed_out <= 1'b0;
`endif
                    end
                end
                ISSUE: begin
                    // Strobe is registered so it starts one clock after gnt
                    if (wr_cnt < CW'(WR_PULSE)) begin
                        IIC_Write <= 1'b1;
                        wr_cnt    <= wr_cnt + CW'(1);
                    end
                    // A fast master may assert busy before the strobe ends
                    if (IIC_Busy) begin
                        busy_seen <= 1'b1;
                    end
                end
                WAIT_BUSY: begin
`ifdef IIC_ARB_TIMEOUT_EN
                    to_cnt <= to_cnt + TW'(1);
                    if (state_next == FINISH) begin
                        timed_out <= 1'b1;
                    end
`endif
                end
                FINISH: begin
                    gnt      <= '0;
                    Ctrl_IIC <= 1'b0;
                    if (winner == PW'(NREQ - 1)) begin
                        ptr <= '0;
                    end else begin
                        ptr <= winner + PW'(1);
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_iic_access_arbiter.sv
// tb/tb_iic_access_arbiter.sv - directed self-checking bench for iic_access_arbiter
`timescale 1ns/1ps
module tb_iic_access_arbiter;

    logic        clk_10MHz = 1'b0;
    logic        rst;
    logic [1:0]  req;
    logic [15:0] req_dev;
    logic [31:0] req_reg;
    logic [15:0] req_dat;
    logic [1:0]  req_reg2;
    logic [1:0]  gnt;
    logic [1:0]  done;
    logic [1:0]  err;
    logic [7:0]  Addr;
    logic [15:0] Reg_Addr;
    logic [7:0]  Reg_Data;
    logic        Reg2Addr;
    logic        IIC_Write;
    logic        IIC_Busy;
    logic        Ctrl_IIC;

    int passed = 0;
    int total  = 0;

    int         w;
    int         lat;
    logic [1:0] dn;
    logic [1:0] er;
    logic [1:0] acc;
    logic [1:0] order [4] = '{2'b01, 2'b10, 2'b01, 2'b10};
    logic [7:0] addr_of [4] = '{8'h6C, 8'h20, 8'h6C, 8'h20};

    always #50 clk_10MHz = ~clk_10MHz;

    iic_access_arbiter #(
        .NREQ     (2),
        .WR_PULSE (10),
        .TIMEOUT  (20)
    ) dut (
        .clk_10MHz (clk_10MHz),
        .rst       (rst),
        .req       (req),
        .req_dev   (req_dev),
        .req_reg   (req_reg),
        .req_dat   (req_dat),
        .req_reg2  (req_reg2),
        .gnt       (gnt),
        .done      (done),
        .err       (err),
        .Addr      (Addr),
        .Reg_Addr  (Reg_Addr),
        .Reg_Data  (Reg_Data),
        .Reg2Addr  (Reg2Addr),
        .IIC_Write (IIC_Write),
        .IIC_Busy  (IIC_Busy),
        .Ctrl_IIC  (Ctrl_IIC)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk_10MHz);
    endtask

    task automatic wait_gnt(output int l);
        l = 0;
        for (int i = 0; i < 20; i++) begin
            tick(1);
            l++;
            if (gnt != 2'b00) break;
        end
    endtask

    // From the grant negedge: measure the strobe, drive busy, then wait for done/err
    task automatic serve(input int rise_at, input int fall_at, input int busy_len,
                         output int wid, output logic [1:0] d, output logic [1:0] e,
                         output int l);
        wid = 0;
        d   = 2'b00;
        e   = 2'b00;
        l   = 0;
        for (int i = 0; i < 40; i++) begin
            tick(1);
            if (IIC_Write) begin
                wid++;
                if (wid == rise_at) IIC_Busy = 1'b1;
                if (wid == fall_at) IIC_Busy = 1'b0;
            end else if (wid > 0) begin
                break;
            end
        end
        if (rise_at == 0) IIC_Busy = 1'b1;
        if (IIC_Busy) begin
            tick(busy_len);
            IIC_Busy = 1'b0;
        end
        for (int i = 0; i < 40; i++) begin
            tick(1);
            l++;
            if (done != 2'b00 || err != 2'b00) begin
                d = done;
                e = err;
                break;
            end
        end
    endtask

    initial begin
        #3000000;
        $display("FAIL watchdog simulation did not finish");
        $fatal(1);
    end

    initial begin
        rst      = 1'b1;
        req      = 2'b00;
        req_dev  = {8'h20, 8'h6C};
        req_reg  = {16'h0033, 16'h0100};
        req_dat  = {8'h44, 8'h01};
        req_reg2 = 2'b01;
        IIC_Busy = 1'b0;
        tick(3);

        check("rst_gnt", gnt, 2'b00);
        check("rst_done", done, 2'b00);
        check("rst_err", err, 2'b00);
        check("rst_write", IIC_Write, 1'b0);
        check("rst_ctrl", Ctrl_IIC, 1'b0);
        check("rst_addr", Addr, 8'h6C);
        check("rst_reg_addr", Reg_Addr, 16'h0000);
        check("rst_reg_data", Reg_Data, 8'h00);
        check("rst_reg2", Reg2Addr, 1'b1);

        rst = 1'b0;
        tick(1);

        // single request from slot 0
        req = 2'b01;
        wait_gnt(lat);
        check("single_gnt_lat", lat, 1);
        check("single_gnt", gnt, 2'b01);
        check("single_ctrl", Ctrl_IIC, 1'b1);
        check("single_addr", Addr, 8'h6C);
        check("single_reg_addr", Reg_Addr, 16'h0100);
        check("single_reg_data", Reg_Data, 8'h01);
        check("single_reg2", Reg2Addr, 1'b1);
        check("single_write_at_gnt", IIC_Write, 1'b0);
        req_dat[7:0] = 8'hFF;
        serve(0, 0, 50, w, dn, er, lat);
        check("single_write_width", w, 10);
        check("single_done", dn, 2'b01);
        check("single_err", er, 2'b00);
        check("single_done_lat", lat, 1);
        check("single_data_held", Reg_Data, 8'h01);
        check("single_gnt_in_finish", gnt, 2'b01);
        req = 2'b00;
        req_dat[7:0] = 8'h01;
        tick(1);
        check("single_gnt_clear", gnt, 2'b00);
        check("single_ctrl_clear", Ctrl_IIC, 1'b0);
        check("single_done_once", done, 2'b00);
        check("single_addr_hold", Addr, 8'h6C);

        // contention with both requesters held, ptr back at 0
        rst = 1'b1;
        tick(1);
        rst = 1'b0;
        req = 2'b11;
        wait_gnt(lat);
        check("rr_first_lat", lat, 1);
        for (int t = 0; t < 4; t++) begin
            if (t > 0) begin
                tick(1);
                check("rr_idle_gap", gnt, 2'b00);
                tick(1);
            end
            check("rr_gnt", gnt, order[t]);
            check("rr_addr", Addr, addr_of[t]);
            serve(0, 0, 5, w, dn, er, lat);
            check("rr_done", dn, order[t]);
        end
        req = 2'b00;
        tick(1);

        // master busy when request arrives: grant waits for busy low
        IIC_Busy = 1'b1;
        req = 2'b10;
        acc = 2'b00;
        for (int i = 0; i < 4; i++) begin
            tick(1);
            acc = acc | gnt;
        end
        check("busy_hold_no_gnt", acc, 2'b00);
        IIC_Busy = 1'b0;
        tick(1);
        check("busy_release_gnt", gnt, 2'b10);
        check("busy_addr", Addr, 8'h20);
        check("busy_reg_addr", Reg_Addr, 16'h0033);
        check("busy_reg_data", Reg_Data, 8'h44);
        check("busy_reg2", Reg2Addr, 1'b0);

        // requester drops mid-transaction; busy rises and falls inside the strobe
        req = 2'b00;
        serve(3, 8, 0, w, dn, er, lat);
        check("early_busy_width", w, 10);
        check("early_busy_done", dn, 2'b10);
        check("early_busy_lat", lat, 2);
        tick(1);

        // busy rises during the strobe and stays high past it
        req = 2'b01;
        wait_gnt(lat);
        check("mid_busy_gnt", gnt, 2'b01);
        serve(3, 0, 6, w, dn, er, lat);
        check("mid_busy_done", dn, 2'b01);
        check("mid_busy_lat", lat, 1);
        req = 2'b00;
        tick(1);

        // reset while in WAIT_DONE
        req = 2'b10;
        wait_gnt(lat);
        check("rstwd_gnt", gnt, 2'b10);
        tick(11);
        IIC_Busy = 1'b1;
        tick(3);
        check("rstwd_write_low", IIC_Write, 1'b0);
        rst = 1'b1;
        req = 2'b00;
        tick(1);
        check("rstwd_gnt_clear", gnt, 2'b00);
        check("rstwd_ctrl_clear", Ctrl_IIC, 1'b0);
        check("rstwd_write", IIC_Write, 1'b0);
        check("rstwd_addr", Addr, 8'h6C);
        rst = 1'b0;
        IIC_Busy = 1'b0;
        acc = 2'b00;
        for (int i = 0; i < 5; i++) begin
            tick(1);
            acc = acc | done | err;
        end
        check("rstwd_no_pulse", acc, 2'b00);
        req = 2'b01;
        wait_gnt(lat);
        check("rstwd_new_gnt", gnt, 2'b01);
        serve(0, 0, 4, w, dn, er, lat);
        check("rstwd_new_done", dn, 2'b01);
        req = 2'b00;
        tick(1);

        // reset during the strobe drops IIC_Write at once
        req = 2'b10;
        wait_gnt(lat);
        tick(3);
        check("rstis_write_high", IIC_Write, 1'b1);
        rst = 1'b1;
        tick(1);
        check("rstis_write_low", IIC_Write, 1'b0);
        rst = 1'b0;
        req = 2'b00;
        tick(1);

`ifdef IIC_ARB_TIMEOUT_EN
        // busy never rises: err after TIMEOUT clocks in WAIT_BUSY, pointer still advances
        req = 2'b01;
        wait_gnt(lat);
        serve(-1, 0, 0, w, dn, er, lat);
        check("to_err", er, 2'b01);
        check("to_no_done", dn, 2'b00);
        check("to_lat", lat, 20);
        req = 2'b11;
        tick(2);
        check("to_ptr_adv", gnt, 2'b10);
        serve(0, 0, 3, w, dn, er, lat);
        check("to_next_done", dn, 2'b10);
        req = 2'b00;
        tick(1);
`endif

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
